// File: rtl/dmem_wbuf_responder_pkg.sv
// Shared widths and sizes for the data-memory responder and its posted-write buffer.
package dmem_wbuf_responder_pkg;

   localparam int unsigned DMEM_AW            = 8;
   localparam int unsigned DMEM_DW            = 64;
   localparam int unsigned DMEM_WORDS         = 256;
   localparam int unsigned WBUF_DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic [0:DMEM_AW-1] addr;
      logic [0:DMEM_DW-1] data;
   } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write FIFO: holds {addr, data} entries in program order and forwards the
// youngest entry matching a lookup address.
module wbuf_fifo
   import dmem_wbuf_responder_pkg::*;
#(
   parameter int unsigned DEPTH = WBUF_DEPTH_DEFAULT
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               push_i,
   input  logic [0:DMEM_AW-1] push_addr_i,
   input  logic [0:DMEM_DW-1] push_data_i,
   input  logic               pop_i,
   output logic [0:DMEM_AW-1] head_addr_o,
   output logic [0:DMEM_DW-1] head_data_o,
   input  logic [0:DMEM_AW-1] lookup_addr_i,
   output logic               hit_o,
   output logic [0:DMEM_DW-1] hit_data_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;
   wbuf_entry_t     entries_q [DEPTH];

   // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_i && !pop_i) begin
         tail_d  = tail_q + PtrW'(1);
         count_d = count_q + CntW'(1);
      end else if (pop_i && !push_i) begin
         head_d  = head_q + PtrW'(1);
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (push_i) begin
         entries_q[tail_q] <= '{addr: push_addr_i, data: push_data_i};
      end
   end

   assign head_addr_o = entries_q[head_q].addr;
   assign head_data_o = entries_q[head_q].data;
   assign full_o      = (count_q == CntW'(DEPTH));
   assign empty_o     = (count_q == '0);

   // Walk oldest to youngest so the last match, the youngest, wins.
   always_comb begin
      hit_o      = 1'b0;
      hit_data_o = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((CntW'(i) < count_q) && (entries_q[head_q + PtrW'(i)].addr == lookup_addr_i)) begin
            hit_o      = 1'b1;
            hit_data_o = entries_q[head_q + PtrW'(i)].data;
         end
      end
   end

endmodule

// File: rtl/dmem_wbuf_responder.sv
// Data-memory responder: writes are posted into a FIFO and drained into MEM on idle
// cycles; reads are answered combinationally with forwarding from pending writes.
module dmem_wbuf_responder
   import dmem_wbuf_responder_pkg::*;
#(
   parameter int unsigned DEPTH = WBUF_DEPTH_DEFAULT
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               DmemEn,
   input  logic               DmemWrEn,
   input  logic [0:DMEM_AW-1] Mem_Addr,
   input  logic [0:DMEM_DW-1] Data_Out,
   output logic [0:DMEM_DW-1] Data_In,
   output logic               Mem_Stall,
   output logic               Wbuf_Empty
);

   logic [0:DMEM_DW-1] MEM [0:DMEM_WORDS-1];

   logic               accept;
   logic               drain;
   logic               full;
   logic               empty;
   logic               hit;
   logic [0:DMEM_DW-1] hit_data;
   logic [0:DMEM_AW-1] head_addr;
   logic [0:DMEM_DW-1] head_data;

   // Accept and drain are mutually exclusive: drain needs the port idle.
   assign accept    = DmemEn & DmemWrEn & ~full;
   assign Mem_Stall = DmemEn & DmemWrEn & full;
   assign drain     = ~DmemEn & ~empty;

   wbuf_fifo #(
      .DEPTH (DEPTH)
   ) u_wbuf (
      .Clock         (Clock),
      .Reset         (Reset),
      .push_i        (accept),
      .push_addr_i   (Mem_Addr),
      .push_data_i   (Data_Out),
      .pop_i         (drain),
      .head_addr_o   (head_addr),
      .head_data_o   (head_data),
      .lookup_addr_i (Mem_Addr),
      .hit_o         (hit),
      .hit_data_o    (hit_data),
      .full_o        (full),
      .empty_o       (empty)
   );

   // MEM is deliberately outside reset so preloaded contents survive it.
   always_ff @(posedge Clock) begin
      if (drain) begin
         MEM[head_addr] <= head_data;
      end
   end

   always_comb begin
      Data_In = '0;
      if (DmemEn && !DmemWrEn) begin
         Data_In = hit ? hit_data : MEM[Mem_Addr];
      end
   end

   assign Wbuf_Empty = empty;

endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Directed bench for dmem_wbuf_responder with a reference model and expected-result queue.
module tb_dmem_wbuf_responder;

   localparam int unsigned DEPTH = 4;

   logic        Clock;
   logic        Reset;
   logic        DmemEn;
   logic        DmemWrEn;
   logic [0:7]  Mem_Addr;
   logic [0:63] Data_Out;
   logic [0:63] Data_In;
   logic        Mem_Stall;
   logic        Wbuf_Empty;

   dmem_wbuf_responder #(
      .DEPTH (DEPTH)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .DmemEn     (DmemEn),
      .DmemWrEn   (DmemWrEn),
      .Mem_Addr   (Mem_Addr),
      .Data_Out   (Data_Out),
      .Data_In    (Data_In),
      .Mem_Stall  (Mem_Stall),
      .Wbuf_Empty (Wbuf_Empty)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic [7:0]  addr;
      logic [63:0] data;
   } pend_t;

   typedef struct {
      logic [63:0] din;
      logic        stall;
      logic        empty;
   } exp_t;

   logic [63:0] mem_model [256];
   pend_t       pend [$];
   exp_t        exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_read(input logic [7:0] a);
      logic [63:0] v;
      v = mem_model[a];
      foreach (pend[i]) if (pend[i].addr == a) v = pend[i].data;
      return v;
   endfunction

   // Entered just after a rising edge; leaves just after the next one.
   task automatic cycle(input logic en, input logic we, input logic [7:0] a,
                        input logic [63:0] d);
      exp_t  e;
      exp_t  got;
      logic  is_full;
      DmemEn   = en;
      DmemWrEn = we;
      Mem_Addr = a;
      Data_Out = d;
      is_full  = (pend.size() == DEPTH);
      e.din    = (en && !we) ? model_read(a) : 64'h0;
      e.stall  = en & we & is_full;
      e.empty  = (pend.size() == 0);
      exp_q.push_back(e);
      @(negedge Clock);
      if (exp_q.size() == 0) begin
         $display("FAIL scoreboard: observed empty queue, expected an entry");
         $fatal(1);
      end
      got = exp_q.pop_front();
      check("data_in", 64'(Data_In), got.din);
      check("stall", 64'(Mem_Stall), 64'(got.stall));
      check("empty", 64'(Wbuf_Empty), 64'(got.empty));
      if (en && we && !is_full) begin
         pend.push_back('{addr: a, data: d});
      end else if (!en && pend.size() > 0) begin
         mem_model[pend[0].addr] = pend[0].data;
         void'(pend.pop_front());
      end
      @(posedge Clock);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [63:0] d);
      cycle(1'b1, 1'b1, a, d);
   endtask

   task automatic rd(input logic [7:0] a);
      cycle(1'b1, 1'b0, a, 64'h0);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 8'h0, 64'h0);
   endtask

   initial begin
      Reset    = 1'b1;
      DmemEn   = 1'b0;
      DmemWrEn = 1'b0;
      Mem_Addr = '0;
      Data_Out = '0;
      #1;
      for (int i = 0; i < 256; i++) begin
         mem_model[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
         dut.MEM[i]   = mem_model[i];
      end
      mem_model[5] = 64'hAAAA;
      dut.MEM[5]   = 64'hAAAA;

      // Reset state
      @(negedge Clock);
      check("rst_data_in", 64'(Data_In), 64'h0);
      check("rst_stall", 64'(Mem_Stall), 64'h0);
      check("rst_empty", 64'(Wbuf_Empty), 64'h1);
      @(posedge Clock);
      #1;
      Reset = 1'b0;

      // Preloaded read
      rd(8'd5);

      // Forwarding of youngest duplicate, then FIFO drain
      wr(8'd5, 64'h1111);
      wr(8'd5, 64'h2222);
      rd(8'd5);
      check("mem5_before_drain", 64'(dut.MEM[5]), 64'hAAAA);
      idle();
      idle();
      check("mem5_after_drain", 64'(dut.MEM[5]), 64'h2222);
      check("empty_after_drain", 64'(Wbuf_Empty), 64'h1);

      // Fill to full, stall on fifth, retry after one idle cycle
      for (int i = 0; i < 5; i++) wr(8'(i), 64'h3000 + 64'(i));
      idle();
      check("cnt_after_full_drain", 64'(dut.u_wbuf.count_q), 64'd3);
      wr(8'd4, 64'h3004);
      for (int i = 0; i < 4; i++) idle();
      for (int i = 0; i < 5; i++) check("mem_fill", 64'(dut.MEM[i]), 64'h3000 + 64'(i));

      // Reads hold off draining
      wr(8'd20, 64'h2020);
      wr(8'd21, 64'h2021);
      wr(8'd22, 64'h2022);
      rd(8'd21);
      check("cnt_rd1", 64'(dut.u_wbuf.count_q), 64'd3);
      rd(8'd30);
      check("cnt_rd2", 64'(dut.u_wbuf.count_q), 64'd3);
      rd(8'd22);
      check("cnt_rd3", 64'(dut.u_wbuf.count_q), 64'd3);
      idle();
      check("cnt_idle", 64'(dut.u_wbuf.count_q), 64'd2);
      idle();
      idle();

      // Asynchronous reset mid-cycle discards pending writes
      wr(8'd40, 64'h4040);
      wr(8'd41, 64'h4041);
      wr(8'd42, 64'h4042);
      DmemEn   = 1'b0;
      DmemWrEn = 1'b0;
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst_empty", 64'(Wbuf_Empty), 64'h1);
      check("async_rst_cnt", 64'(dut.u_wbuf.count_q), 64'd0);
      pend.delete();
      #1;
      Reset = 1'b0;
      @(posedge Clock);
      #1;
      for (int i = 0; i < 3; i++) idle();
      for (int i = 40; i < 43; i++)
         check("mem_after_rst", 64'(dut.MEM[i]), 64'hC0DE_0000_0000_0000 | 64'(i));

      // First write after reset lands in entry 0
      wr(8'd50, 64'h5050);
      check("entry0_data", 64'(dut.u_wbuf.entries_q[0].data), 64'h5050);
      idle();
      check("mem50", 64'(dut.MEM[50]), 64'h5050);

      // Pointer wrap with alternating write/idle
      for (int i = 0; i < 10; i++) begin
         wr(8'(8 + i), 64'h8000 + 64'(i));
         idle();
      end
      for (int i = 0; i < 10; i++) check("mem_wrap", 64'(dut.MEM[8 + i]), 64'h8000 + 64'(i));

      // Whole-array comparison against the model
      for (int i = 0; i < 256; i++) check("mem_dump", 64'(dut.MEM[i]), mem_model[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
